// File: rtl/d_ff_share_arb.sv
// Round-robin arbiter sharing one registered WIDTH-bit flop bank among NREQ requesters.
// A winner is granted for one cycle. Its data is captured on the following edge.
// The value is then held before the bank is offered to the next requester.
//
// state | meaning
// IDLE  | bank free; arbitrate on any request
// GRANT | one-hot grant out; capture on next edge if the winner still requests
// HOLD  | captured value held; requests wait until IDLE
module d_ff_share_arb #(
    parameter  int NREQ        = 4,
    parameter  int WIDTH       = 8,
    parameter  int HOLD_CYCLES = 2,
    localparam int PW          = $clog2(NREQ),
    localparam int CW          = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] d_in_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [WIDTH-1:0]      d_out_o,
    output logic                  upd_o,
    output logic                  abort_o,
    output logic [PW-1:0]         owner_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  d_out_q, d_out_d;
    logic              upd_q, upd_d;
    logic              abort_q, abort_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     win_next;

    // Round-robin pick: scan from ptr upward with wrap. Scanning from the far end
    // and overwriting leaves the first hit in scan order.
    always_comb begin
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_i[idx]) win_idx = PW'(idx);
        end
        win_next = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + PW'(1);
    end

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        d_out_d = d_out_q;
        upd_d   = 1'b0;
        abort_d = 1'b0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i != '0) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    ptr_d          = win_next;
                    state_d        = GRANT;
                end
            end
            GRANT: begin
                if (req_i[owner_q]) begin
                    d_out_d = d_in_i[int'(owner_q)*WIDTH +: WIDTH];
                    upd_d   = 1'b1;
                    // The capture cycle plus HOLD_CYCLES further cycles are spent in HOLD,
                    // giving a HOLD_CYCLES+3 grant period under continuous request.
                    cnt_d   = CW'(HOLD_CYCLES);
                    state_d = HOLD;
                end else begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            d_out_q <= '0;
            upd_q   <= 1'b0;
            abort_q <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            d_out_q <= d_out_d;
            upd_q   <= upd_d;
            abort_q <= abort_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign d_out_o = d_out_q;
    assign upd_o   = upd_q;
    assign abort_o = abort_q;
    assign owner_o = owner_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_d_ff_share_arb.sv
// Bench for d_ff_share_arb: schedule-based reference model, directed scenarios and random traffic.
module tb_d_ff_share_arb;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int HOLD  = 2;
    localparam int PW    = $clog2(NREQ);

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] d_in;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      d_out;
    logic                  upd;
    logic                  abort_p;
    logic [PW-1:0]         owner;
    logic                  busy;

    d_ff_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .d_in_i(d_in),
        .gnt_o(gnt), .d_out_o(d_out), .upd_o(upd), .abort_o(abort_p),
        .owner_o(owner), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int e      = 0;

    // Reference model: tracks when the bank is next free rather than any state encoding.
    bit              m_valid = 0;
    bit              m_pending;
    int              m_free_at;
    int              m_ptr;
    int              m_owner;
    logic [WIDTH-1:0] m_dout;
    logic [NREQ-1:0] m_gnt;
    bit              m_upd, m_abort, m_busy;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e);
        end
    endtask

    task automatic model_step();
        int w;
        bit found;
        e++;
        if (rst) begin
            m_valid = 1; m_pending = 0; m_free_at = e + 1; m_ptr = 0; m_owner = 0;
            m_dout = '0; m_gnt = '0; m_upd = 0; m_abort = 0; m_busy = 0;
            return;
        end
        if (!m_valid) return;
        m_gnt = '0; m_upd = 0; m_abort = 0;
        if (m_pending) begin
            m_pending = 0;
            if (req[m_owner]) begin
                m_dout    = d_in[m_owner*WIDTH +: WIDTH];
                m_upd     = 1;
                m_free_at = e + HOLD + 2;
            end else begin
                m_abort   = 1;
                m_free_at = e + 1;
            end
        end else if (e >= m_free_at && req != '0) begin
            found = 0; w = 0;
            for (int k = 0; k < NREQ; k++)
                if (!found && req[(m_ptr + k) % NREQ]) begin
                    found = 1;
                    w = (m_ptr + k) % NREQ;
                end
            m_gnt     = NREQ'(1) << w;
            m_owner   = w;
            m_ptr     = (w + 1) % NREQ;
            m_pending = 1;
        end
        m_busy = m_pending || (e < m_free_at - 1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_valid) begin
            chk("gnt",   32'(gnt),     32'(m_gnt));
            chk("d_out", 32'(d_out),   32'(m_dout));
            chk("upd",   32'(upd),     32'(m_upd));
            chk("abort", 32'(abort_p), 32'(m_abort));
            chk("owner", 32'(owner),   32'(m_owner));
            chk("busy",  32'(busy),    32'(m_busy));
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((busy !== 1'b0 || m_busy) && i < 40) begin
            cycle();
            i++;
        end
        if (i >= 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: got busy %0b expected 0 within 40 cycles", busy);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        cycle();
        rst = 1'b0;
    endtask

    bit drop_next [NREQ];

    initial begin
        rst = 1'b1; req = '0; d_in = '0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_gnt",  32'(gnt),   32'h0);
        chk("rst_dout", 32'(d_out), 32'h0);
        chk("rst_busy", 32'(busy),  32'h0);

        // Reset mid-GRANT: no capture, pointer back to 0.
        req = 4'b0001; d_in[7:0] = 8'h5A;
        cycle();
        chk("t1_gnt", 32'(gnt), 32'h1);
        rst = 1'b1;
        cycle();
        cycle();
        chk("t1_gnt0",  32'(gnt),   32'h0);
        chk("t1_dout0", 32'(d_out), 32'h0);
        chk("t1_upd0",  32'(upd),   32'h0);
        chk("t1_busy0", 32'(busy),  32'h0);
        rst = 1'b0; req = 4'b1001;
        cycle();
        chk("t1_ptr0", 32'(gnt), 32'h1);
        cycle();
        req = '0;
        wait_idle();

        // Single requester latency.
        do_reset();
        req = 4'b0001; d_in[7:0] = 8'hA5;
        cycle();
        chk("t2_gnt", 32'(gnt), 32'h1);
        cycle();
        chk("t2_dout", 32'(d_out), 32'hA5);
        chk("t2_upd",  32'(upd),   32'h1);
        req = '0;
        cycle();
        cycle();
        chk("t2_busy_hold", 32'(busy), 32'h1);
        cycle();
        chk("t2_busy_low", 32'(busy), 32'h0);

        // All four held: rotation every HOLD+3 cycles.
        do_reset();
        for (int i = 0; i < NREQ; i++) d_in[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);
        req = 4'b1111;
        for (int k = 0; k < 25; k++) begin
            cycle();
            if (k % 5 == 0) chk("t3_gnt", 32'(gnt), 32'(1) << ((k / 5) % 4));
            else            chk("t3_gnt_idle", 32'(gnt), 32'h0);
            if (k % 5 == 1) begin
                chk("t3_dout", 32'(d_out), 32'h10 + (k / 5) % 4);
                chk("t3_upd",  32'(upd),   32'h1);
            end
        end
        req = '0;
        wait_idle();

        // Wrap: grant 2 (ptr->3), then 0101 wins at 0, ptr->1.
        req = 4'b0100; d_in[23:16] = 8'h33;
        cycle();
        chk("t4_g2", 32'(gnt), 32'h4);
        cycle();
        req = '0;
        wait_idle();
        req = 4'b0101; d_in[7:0] = 8'h44;
        cycle();
        chk("t4_gnt",   32'(gnt),   32'h1);
        chk("t4_owner", 32'(owner), 32'h0);
        cycle();
        req = 4'b0110; d_in[15:8] = 8'h55;
        wait_idle();
        cycle();
        chk("t4_ptr1", 32'(gnt), 32'h2);
        cycle();
        chk("t4_dout", 32'(d_out), 32'h55);
        req = '0;
        wait_idle();

        // Abort: drop request during GRANT.
        req = 4'b0010; d_in[15:8] = 8'h66;
        cycle();
        chk("t5_gnt", 32'(gnt), 32'h2);
        req = '0;
        cycle();
        chk("t5_abort", 32'(abort_p), 32'h1);
        chk("t5_upd",   32'(upd),     32'h0);
        chk("t5_dout",  32'(d_out),   32'h55);
        chk("t5_busy",  32'(busy),    32'h0);
        cycle();
        chk("t5_abort_clr", 32'(abort_p), 32'h0);

        // Request arriving during HOLD waits for IDLE.
        req = 4'b0001; d_in[7:0] = 8'h77;
        cycle();
        chk("t6_gnt0", 32'(gnt), 32'h1);
        cycle();
        chk("t6_dout", 32'(d_out), 32'h77);
        req = 4'b1000; d_in[31:24] = 8'h88;
        cycle();
        chk("t6_wait_a", 32'(gnt), 32'h0);
        cycle();
        chk("t6_wait_b", 32'(gnt), 32'h0);
        cycle();
        chk("t6_wait_c", 32'(gnt),  32'h0);
        chk("t6_idle",   32'(busy), 32'h0);
        cycle();
        chk("t6_gnt3", 32'(gnt), 32'h8);
        cycle();
        chk("t6_dout3", 32'(d_out), 32'h88);
        req = '0;
        wait_idle();

        // Random traffic from contract-abiding requesters, with occasional aborts and resets.
        for (int i = 0; i < NREQ; i++) drop_next[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && m_gnt[i]) begin
                    if ($urandom_range(0, 5) == 0) req[i] = 1'b0;
                    else drop_next[i] = 1;
                end else if (drop_next[i]) begin
                    req[i] = 1'b0;
                    drop_next[i] = 0;
                end else if (!req[i] && $urandom_range(0, 4) == 0) begin
                    req[i] = 1'b1;
                    d_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            cycle();
        end
        rst = 1'b0; req = '0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
